// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcode encoding, the queued
// command record and the datapath width.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    SHL = 3'b010,
    SHR = 3'b011,
    AND = 3'b100,
    OR  = 3'b101,
    XOR = 3'b110,
    EQ  = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e            op;
    logic [ALU_W-1:0]   a;
    logic [ALU_W-1:0]   b;
    logic               acc;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command FIFO. Pointers wrap naturally because DEPTH is a power of
// two. Storage is not reset; only pointers and occupancy are. A push while
// full is ignored, so a same-cycle pop never opens a slot for that push.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_cmd_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;

  // Next pointer/occupancy: clear empties the queue and overrides push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Command storage, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: queues commands, presents the head to an external
// combinational ALU, captures its result into a one-entry result register
// and keeps the last result as an accumulator for chained commands.
//
// Handshakes are strict valid/ready: a transfer happens exactly at a rising
// edge where valid and ready are both high; valid never depends on ready.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [2:0]              cmd_op_i,
  input  logic [ALU_W-1:0]        cmd_a_i,
  input  logic [ALU_W-1:0]        cmd_b_i,
  input  logic                    cmd_acc_i,
  output logic [2:0]              alu_op_o,
  output logic [ALU_W-1:0]        alu_a_o,
  output logic [ALU_W-1:0]        alu_b_o,
  input  logic [ALU_W-1:0]        alu_res_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [ALU_W-1:0]        res_data_o,
  output logic [2:0]              res_op_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  alu_cmd_t          cmd_in, head;
  logic              full, empty, push, issue;
  logic              res_valid_q, res_valid_d;
  logic [ALU_W-1:0]  res_data_q,  res_data_d;
  logic [2:0]        res_op_q,    res_op_d;
  logic [ALU_W-1:0]  acc_q,       acc_d;

  assign cmd_in      = '{op: alu_op_e'(cmd_op_i), a: cmd_a_i, b: cmd_b_i, acc: cmd_acc_i};
  assign cmd_ready_o = !full && !clear_i;
  assign push        = cmd_valid_i && cmd_ready_o;
  // Issue when a command waits and the result register is free or draining.
  assign issue       = !empty && (!res_valid_q || res_ready_i) && !clear_i;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (alu_cmd_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (cmd_in),
    .pop_i   (issue),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  // Drive the ALU from the FIFO head; quiet zeros when nothing is queued.
  always_comb begin
    alu_op_o = '0;
    alu_a_o  = '0;
    alu_b_o  = '0;
    if (!empty) begin
      alu_op_o = head.op;
      alu_a_o  = head.acc ? acc_q : head.a;
      alu_b_o  = head.b;
    end
  end

  // Result/accumulator next state: clear wins, then capture, then drain.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    acc_d       = acc_q;
    if (clear_i) begin
      res_valid_d = 1'b0;
      res_data_d  = '0;
      res_op_d    = '0;
      acc_d       = '0;
    end else if (issue) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_res_i;
      res_op_d    = head.op;
      acc_d       = alu_res_i;
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  // Result register and accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      acc_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      acc_q       <= acc_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_op_o    = res_op_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Testbench for alu_cmd_seq: reference 8-bit ALU, in-order result model with
// accumulator tracking, and directed plus randomized scenarios.
module tb_alu_cmd_seq;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [2:0]    cmd_op_i;
  logic [7:0]    cmd_a_i;
  logic [7:0]    cmd_b_i;
  logic          cmd_acc_i;
  logic [2:0]    alu_op_o;
  logic [7:0]    alu_a_o;
  logic [7:0]    alu_b_o;
  logic [7:0]    alu_res_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [7:0]    res_data_o;
  logic [2:0]    res_op_o;
  logic [CW-1:0] count_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected results in acceptance order: {op, data}.
  logic [10:0] exp_q[$];
  logic [7:0]  model_acc;
  logic [10:0] exp_v;
  logic [7:0]  a_eff;
  logic [7:0]  r_v;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_a_i     (cmd_a_i),
    .cmd_b_i     (cmd_b_i),
    .cmd_acc_i   (cmd_acc_i),
    .alu_op_o    (alu_op_o),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_res_i   (alu_res_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .res_op_o    (res_op_o),
    .count_o     (count_o)
  );

  // ---------------- reference ALU ----------------
  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << b[2:0];
      3'd3:    return a >> b[2:0];
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return {7'b0, (a == b)};
    endcase
  endfunction

  assign alu_res_i = alu_ref(alu_op_o, alu_a_o, alu_b_o);

  // ---------------- scoreboard ----------------
  // Inputs change 1 time unit after a rising edge, so at the falling edge
  // both the inputs for the coming edge and the DUT outputs are stable.
  always @(negedge clk) begin
    if (!reset_n || clear_i) begin
      exp_q.delete();
      model_acc = 8'd0;
    end else begin
      if (res_valid_o && res_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_result: got op=%0d data=%0d, required no result pending", res_op_o, res_data_o);
        end else begin
          exp_v = exp_q.pop_front();
          if ({res_op_o, res_data_o} !== exp_v)
            $display("FAIL sb_result: got op=%0d data=%0d, required op=%0d data=%0d",
                     res_op_o, res_data_o, exp_v[10:8], exp_v[7:0]);
          else n_pass++;
        end
      end
      if (cmd_valid_i && cmd_ready_o) begin
        a_eff     = cmd_acc_i ? model_acc : cmd_a_i;
        r_v       = alu_ref(cmd_op_i, a_eff, cmd_b_i);
        model_acc = r_v;
        exp_q.push_back({cmd_op_i, r_v});
      end
      n_checks++;
      if (count_o > CW'(DEPTH)) $display("FAIL count_bound: got %0d, required <= %0d", count_o, DEPTH);
      else n_pass++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic acc);
    cmd_valid_i = v;
    cmd_op_i    = op;
    cmd_a_i     = a;
    cmd_b_i     = b;
    cmd_acc_i   = acc;
  endtask

  task automatic set_rand_cmd();
    set_cmd(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  // Push n random commands with whatever res_ready_i is currently set.
  task automatic fill(input int n);
    int   pushed = 0;
    logic acc_ok;
    for (int c = 0; c < n + 10 && pushed < n; c++) begin
      set_rand_cmd();
      acc_ok = cmd_ready_o;
      tick();
      if (acc_ok) pushed++;
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    cmd_valid_i = 1'b0;
    res_ready_i = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || res_valid_o); i++) tick();
    n_checks++;
    if (exp_q.size() != 0 || res_valid_o)
      $display("FAIL drain: got %0d results outstanding valid=%0b, required 0 and 0", exp_q.size(), res_valid_o);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; clear_i = 1'b0; res_ready_i = 1'b0;
    set_cmd(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    #3;
    n_checks++; if (count_o !== '0)     $display("FAIL rst_count: got %0d, required 0", count_o); else n_pass++;
    n_checks++; if (res_valid_o !== 1'b0) $display("FAIL rst_valid: got %0b, required 0", res_valid_o); else n_pass++;
    n_checks++; if (res_data_o !== 8'd0) $display("FAIL rst_data: got %0d, required 0", res_data_o); else n_pass++;
    n_checks++; if (res_op_o !== 3'd0)   $display("FAIL rst_op: got %0d, required 0", res_op_o); else n_pass++;
    n_checks++; if (cmd_ready_o !== 1'b1) $display("FAIL rst_ready: got %0b, required 1", cmd_ready_o); else n_pass++;
    n_checks++; if ({alu_op_o, alu_a_o, alu_b_o} !== 19'd0) $display("FAIL rst_alu: got %0h, required 0", {alu_op_o, alu_a_o, alu_b_o}); else n_pass++;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    res_ready_i = 1'b1;
    set_cmd(1'b1, 3'd0, 8'd5, 8'd3, 1'b0);
    tick();
    set_cmd(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    n_checks++; if (res_valid_o !== 1'b0) $display("FAIL single_lat0: got %0b, required 0", res_valid_o); else n_pass++;
    n_checks++; if (count_o !== CW'(1)) $display("FAIL single_count: got %0d, required 1", count_o); else n_pass++;
    n_checks++; if ({alu_a_o, alu_b_o} !== {8'd5, 8'd3}) $display("FAIL single_alu: got a=%0d b=%0d, required a=5 b=3", alu_a_o, alu_b_o); else n_pass++;
    tick();
    n_checks++; if (res_valid_o !== 1'b1) $display("FAIL single_valid: got %0b, required 1", res_valid_o); else n_pass++;
    n_checks++; if (res_data_o !== 8'd8) $display("FAIL single_data: got %0d, required 8", res_data_o); else n_pass++;
    n_checks++; if (res_op_o !== 3'd0) $display("FAIL single_op: got %0d, required 0", res_op_o); else n_pass++;
    drain();
  endtask

  task automatic test_chain();
    res_ready_i = 1'b1;
    set_cmd(1'b1, 3'd0, 8'd10, 8'd20, 1'b0);
    tick();
    set_cmd(1'b1, 3'd1, 8'($urandom_range(0, 255)), 8'd4, 1'b1);
    tick();
    n_checks++; if (res_data_o !== 8'd30) $display("FAIL chain_add: got %0d, required 30", res_data_o); else n_pass++;
    n_checks++; if (alu_a_o !== 8'd30) $display("FAIL chain_acc_fwd: got %0d, required 30", alu_a_o); else n_pass++;
    set_cmd(1'b1, 3'd2, 8'($urandom_range(0, 255)), 8'd1, 1'b1);
    tick();
    n_checks++; if (res_data_o !== 8'd26) $display("FAIL chain_sub: got %0d, required 26", res_data_o); else n_pass++;
    set_cmd(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    tick();
    n_checks++; if ({res_op_o, res_data_o} !== {3'd2, 8'd52}) $display("FAIL chain_shl: got op=%0d data=%0d, required op=2 data=52", res_op_o, res_data_o); else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    res_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_rand_cmd();
      tick();
      if (i > 0) begin
        n_checks++;
        if (res_valid_o !== 1'b1) $display("FAIL b2b_valid[%0d]: got %0b, required 1", i, res_valid_o); else n_pass++;
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [10:0] held;
    logic        acc_ok = 1'b0;
    res_ready_i = 1'b0;
    fill(5);
    set_rand_cmd();
    tick(); tick();
    n_checks++; if (cmd_ready_o !== 1'b0) $display("FAIL bp_ready: got %0b, required 0", cmd_ready_o); else n_pass++;
    n_checks++; if (count_o !== CW'(4)) $display("FAIL bp_count: got %0d, required 4", count_o); else n_pass++;
    n_checks++; if (exp_q.size() != 5) $display("FAIL bp_accepted: got %0d, required 5", exp_q.size()); else n_pass++;
    held = exp_q[0];
    n_checks++; if ({res_op_o, res_data_o} !== held) $display("FAIL bp_head: got %0h, required %0h", {res_op_o, res_data_o}, held); else n_pass++;
    tick();
    n_checks++; if ({res_valid_o, res_op_o, res_data_o} !== {1'b1, held}) $display("FAIL bp_stable: got %0h, required %0h", {res_valid_o, res_op_o, res_data_o}, {1'b1, held}); else n_pass++;
    res_ready_i = 1'b1;
    for (int i = 0; i < 10 && !acc_ok; i++) begin
      acc_ok = cmd_ready_o;
      tick();
    end
    n_checks++; if (acc_ok !== 1'b1) $display("FAIL bp_sixth: got accepted=%0b, required 1", acc_ok); else n_pass++;
    drain();
  endtask

  task automatic test_full();
    res_ready_i = 1'b0;
    fill(5);
    set_rand_cmd();
    n_checks++; if ({cmd_ready_o, count_o} !== {1'b0, CW'(4)}) $display("FAIL full_pre: got ready=%0b count=%0d, required 0 4", cmd_ready_o, count_o); else n_pass++;
    res_ready_i = 1'b1;
    tick();
    n_checks++; if ({cmd_ready_o, count_o} !== {1'b1, CW'(3)}) $display("FAIL full_pop_only: got ready=%0b count=%0d, required 1 3", cmd_ready_o, count_o); else n_pass++;
    tick();
    n_checks++; if (count_o !== CW'(3)) $display("FAIL full_push_pop: got %0d, required 3", count_o); else n_pass++;
    drain();
  endtask

  task automatic test_clear();
    res_ready_i = 1'b0;
    fill(4);
    n_checks++; if ({res_valid_o, count_o} !== {1'b1, CW'(3)}) $display("FAIL clr_pre: got valid=%0b count=%0d, required 1 3", res_valid_o, count_o); else n_pass++;
    set_rand_cmd();
    clear_i = 1'b1;
    res_ready_i = 1'b1;
    #1;
    n_checks++; if (cmd_ready_o !== 1'b0) $display("FAIL clr_ready: got %0b, required 0", cmd_ready_o); else n_pass++;
    tick();
    clear_i = 1'b0;
    cmd_valid_i = 1'b0;
    n_checks++; if ({res_valid_o, count_o} !== {1'b0, CW'(0)}) $display("FAIL clr_flush: got valid=%0b count=%0d, required 0 0", res_valid_o, count_o); else n_pass++;
    n_checks++; if ({res_op_o, res_data_o} !== 11'd0) $display("FAIL clr_res: got op=%0d data=%0d, required 0 0", res_op_o, res_data_o); else n_pass++;
    set_cmd(1'b1, 3'd0, 8'($urandom_range(1, 255)), 8'd7, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    n_checks++; if ({res_valid_o, res_data_o} !== {1'b1, 8'd7}) $display("FAIL clr_acc: got valid=%0b data=%0d, required 1 7", res_valid_o, res_data_o); else n_pass++;
    drain();
  endtask

  task automatic test_reset_midstream();
    res_ready_i = 1'b0;
    fill(3);
    reset_n = 1'b0;
    #1;
    n_checks++; if ({res_valid_o, count_o} !== {1'b0, CW'(0)}) $display("FAIL mrst_state: got valid=%0b count=%0d, required 0 0", res_valid_o, count_o); else n_pass++;
    n_checks++; if ({res_op_o, res_data_o} !== 11'd0) $display("FAIL mrst_res: got op=%0d data=%0d, required 0 0", res_op_o, res_data_o); else n_pass++;
    n_checks++; if ({cmd_ready_o, alu_op_o, alu_a_o} !== {1'b1, 11'd0}) $display("FAIL mrst_io: got %0h, required %0h", {cmd_ready_o, alu_op_o, alu_a_o}, {1'b1, 11'd0}); else n_pass++;
    tick(); tick();
    reset_n = 1'b1;
    res_ready_i = 1'b1;
    set_cmd(1'b1, 3'd1, 8'd9, 8'd4, 1'b0);
    tick();
    cmd_valid_i = 1'b0;
    n_checks++; if (res_valid_o !== 1'b0) $display("FAIL mrst_stale: got %0b, required 0", res_valid_o); else n_pass++;
    tick();
    n_checks++; if ({res_valid_o, res_op_o, res_data_o} !== {1'b1, 3'd1, 8'd5}) $display("FAIL mrst_first: got valid=%0b op=%0d data=%0d, required 1 1 5", res_valid_o, res_op_o, res_data_o); else n_pass++;
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) < 70) set_rand_cmd();
      else cmd_valid_i = 1'b0;
      res_ready_i = ($urandom_range(0, 99) < 60);
      clear_i     = ($urandom_range(0, 99) < 2);
      tick();
    end
    clear_i = 1'b0;
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_acc = 8'd0;
    test_reset();
    test_single();
    test_chain();
    test_back_to_back();
    test_backpressure();
    test_full();
    test_clear();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
